mfe_led7seg_74hc595_arb: RTL
============================

MFE_LED7SEG_74HC595_ARB -- requirements
Module: mfe_led7seg_74hc595_arb

Interface
REQ-001 Parameter REQ_NUM, default 2, SHALL set the number of display requesters (2..8).
REQ-002 Parameter DIG_NUM, default 8, SHALL set the number of digits; SEG_NUM, default 8, SHALL set segments per digit; DAT_WIDTH = DIG_NUM*SEG_NUM.
REQ-003 Parameter GAP_CYC, default 2048, SHALL set the minimum clk cycles between consecutive out_vld pulses (serializer frame time).
REQ-004 Parameter DWELL_CYC, default 2**20, SHALL set the minimum ownership time before a contending requester can take the display.
REQ-005 clk  input  1  SHALL be the single clock; one clock, all logic on rising edge.
REQ-006 rst_n  input  1  SHALL be the reset, synchronous, active-low.
REQ-007 req  input  REQ_NUM  SHALL be the per-requester level request.
REQ-008 dat  input  REQ_NUM*DAT_WIDTH  SHALL be the per-requester frame; requester i occupies bits [i*DAT_WIDTH +: DAT_WIDTH].
REQ-009 gnt  output  REQ_NUM  SHALL be the one-hot current owner, or all-zero when no owner.
REQ-010 ack  output  REQ_NUM  SHALL be a one-cycle pulse on the bit of the requester whose frame was just latched.
REQ-011 out_dat  output  DAT_WIDTH  SHALL be the latched frame driven to the LED serializer's dat input.
REQ-012 out_vld  output  1  SHALL be a one-cycle pulse to the LED serializer's vld input.

Function
REQ-013 States SHALL be IDLE, LOAD, SEND, HOLD.
REQ-014 IDLE: gnt=0; if any req, round-robin pick starting at the index after the last owner (index 0 after reset) -> LOAD next cycle.
REQ-015 LOAD (1 cycle): out_dat <= selected dat slice; gnt one-hot of selection; ack pulse on that bit -> SEND.
REQ-016 SEND (1 cycle): out_vld=1; gap counter loaded with GAP_CYC-1 -> HOLD.
REQ-017 Dwell counter SHALL clear on an owner change, increment in HOLD, and saturate at DWELL_CYC.
REQ-018 HOLD exits only when the gap counter reaches 0, then: owner req low and other req pending -> arbitrate -> LOAD; owner req low and none pending -> IDLE; owner req high and (no other req or dwell < DWELL_CYC) -> LOAD same owner (refresh); owner req high, other req pending, dwell saturated -> round-robin rotate -> LOAD.
REQ-019 Minimum spacing between out_vld pulses SHALL be GAP_CYC+2 cycles; no out_vld outside SEND.
REQ-020 Round-robin SHALL be starvation-free: with all req high, owners cycle 0,1,..,REQ_NUM-1,0.
REQ-021 Simultaneous req rise on several inputs in IDLE SHALL resolve by round-robin order within one cycle.
REQ-022 dat changes outside LOAD SHALL not affect out_dat.
REQ-023 out_dat SHALL hold its last value in IDLE (display retains frame), unless REQ-027 applies.
REQ-024 Counters SHALL be sized $clog2(GAP_CYC) and $clog2(DWELL_CYC+1) bits; no wrap.

Reset
REQ-025 rst_n low at any state, mid-HOLD included, SHALL force next cycle: IDLE, gnt=0, ack=0, out_vld=0, counters=0, last-owner=REQ_NUM-1, out_dat = all ones (blank, active-low segments).

Configuration
REQ-026 Macro MFE_LED7SEG_ARB_BLANK_EN SHALL select blank-on-release.
REQ-027 Defined: HOLD->IDLE transition SHALL first pass LOAD/SEND once with out_dat all ones, gnt=0, no ack, then enter IDLE after the gap; undefined: go directly to IDLE, out_dat unchanged.

Structure
REQ-028 Package mfe_led7seg_pkg SHALL hold the state enum and BLANK_SEG = 8'hFF.
REQ-029 Sub-module mfe_rr_pick SHALL implement combinational round-robin selection (req vector, last index -> one-hot, valid).

Verification
REQ-030 Reset, req=01, dat0=frame A -> LOAD at cycle 1, ack=01, out_vld at cycle 2, out_dat=A, gnt=01.
REQ-031 req0 held, dat0 changed to B during HOLD -> next out_vld exactly GAP_CYC+2 cycles after previous, out_dat=B.
REQ-032 req=11 continuous, DWELL_CYC=8, GAP_CYC=4 -> gnt toggles 01/10 after dwell, never starves.
REQ-033 Owner drops req, none pending -> IDLE, gnt=0, out_dat holds (macro off) / one blank out_vld with out_dat all ones (macro on).
REQ-034 rst_n low mid-HOLD -> next cycle IDLE, out_dat all ones, no out_vld until new request.
REQ-035 req=111 rise same cycle after reset (REQ_NUM=3) -> grant order 0,1,2.

Source files
------------

// File: rtl/mfe_led7seg_pkg.sv
// Shared types and constants for the LED 7-segment display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfe_led7seg_pkg;

  // Arbiter FSM states: wait for a request, latch a frame, strobe the
  // serializer, then hold the display for one serializer frame time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Segments are active-low, so an all-ones digit is dark.
  localparam logic [7:0] BLANK_SEG = 8'hFF;

endpackage

// File: rtl/mfe_rr_pick.sv
// Combinational round-robin pick: first set request strictly after last_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req_i  [REQ_NUM]  request vector
//   last_i [IDX_W]    index of the previous winner; search starts at last_i+1
//   gnt_o  [REQ_NUM]  one-hot winner, all-zero when nothing requests
//   vld_o             at least one request present
module mfe_rr_pick #(
  parameter int REQ_NUM = 2,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic               vld_o
);

  logic             hi_vld;
  logic             lo_vld;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] win_idx;

  // Two passes: lowest requester above last_i wins; otherwise wrap around
  // and take the lowest requester at or below last_i.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (req_i[i] && !hi_vld && (i > int'(last_i))) begin
        hi_vld = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (req_i[i] && !lo_vld && (i <= int'(last_i))) begin
        lo_vld = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
    vld_o   = hi_vld | lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
    gnt_o   = '0;
    if (vld_o) gnt_o[win_idx] = 1'b1;
  end

endmodule

// File: rtl/mfe_led7seg_74hc595_arb.sv
// Round-robin arbiter sharing one 74HC595 LED serializer among REQ_NUM frame sources.
// Latency: request seen in IDLE -> ack next cycle (LOAD) -> out_vld the cycle after (SEND).
// Backpressure: none on the serializer side; out_vld pulses are spaced >= GAP_CYC+2 cycles.
//
// Ports:
//   clk, rst_n       single clock, synchronous active-low reset
//   req  [REQ_NUM]   level request per source
//   dat  [REQ_NUM*DAT_WIDTH] frame per source, source i at [i*DAT_WIDTH +: DAT_WIDTH]
//   gnt  [REQ_NUM]   one-hot current owner, zero when the display is unowned
//   ack  [REQ_NUM]   one-cycle pulse on the source whose frame was just latched
//   out_dat [DAT_WIDTH] latched frame to the serializer
//   out_vld          one-cycle strobe to the serializer
// Build option: MFE_LED7SEG_ARB_BLANK_EN -- when defined, releasing the display
// sends one all-dark frame (gnt=0, no ack) before returning to IDLE.
module mfe_led7seg_74hc595_arb
  import mfe_led7seg_pkg::*;
#(
  parameter  int REQ_NUM   = 2,        // 2..8
  parameter  int DIG_NUM   = 8,
  parameter  int SEG_NUM   = 8,
  parameter  int GAP_CYC   = 2048,     // >= 2
  parameter  int DWELL_CYC = 2**20,
  localparam int DAT_WIDTH = DIG_NUM * SEG_NUM
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req,
  input  logic [REQ_NUM*DAT_WIDTH-1:0] dat,
  output logic [REQ_NUM-1:0]           gnt,
  output logic [REQ_NUM-1:0]           ack,
  output logic [DAT_WIDTH-1:0]         out_dat,
  output logic                         out_vld
);

  localparam int IDX_W = $clog2(REQ_NUM);
  localparam int GAP_W = $clog2(GAP_CYC);
  localparam int DW_W  = $clog2(DWELL_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_CYC);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;     // also the round-robin "last" pointer
  logic                   own_vld_q, own_vld_d; // low during a blank frame or when unowned
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DW_W-1:0]        dwell_q, dwell_d;
  logic [DAT_WIDTH-1:0]   out_dat_q, out_dat_d;
  logic                   dwell_clr;

  logic [REQ_NUM-1:0]     owner_oh;
  logic [REQ_NUM-1:0]     others;
  logic                   owner_req;
  logic                   dwell_sat;
  logic [REQ_NUM-1:0]     pick_oh;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic [DAT_WIDTH-1:0]   sel_dat;

  mfe_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (req),
    .last_i (owner_q),
    .gnt_o  (pick_oh),
    .vld_o  (pick_vld)
  );

  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    pick_idx = '0;
    sel_dat  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
      if (owner_q == IDX_W'(i)) sel_dat = dat[i*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  assign others    = req & ~owner_oh;
  assign owner_req = req[owner_q];
  assign dwell_sat = (dwell_q == DWELL_MAX);

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= IDX_W'(REQ_NUM - 1);   // first pick after reset lands on 0
      own_vld_q <= 1'b0;
      gap_q     <= '0;
      dwell_q   <= '0;
      out_dat_q <= '1;                    // dark display
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      own_vld_q <= own_vld_d;
      gap_q     <= gap_d;
      dwell_q   <= dwell_d;
      out_dat_q <= out_dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    own_vld_d = own_vld_q;
    dwell_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        own_vld_d = 1'b0;
        if (pick_vld) begin
          state_d   = ST_LOAD;
          owner_d   = pick_idx;
          own_vld_d = 1'b1;
          dwell_clr = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: state_d = ST_HOLD;
      ST_HOLD: begin
        if (gap_q == '0) begin
          if (!own_vld_q) begin
            state_d = ST_IDLE;            // blank frame finished
          end else if (!owner_req) begin
            if (|others) begin
              state_d   = ST_LOAD;
              owner_d   = pick_idx;
              dwell_clr = 1'b1;
            end else begin
              own_vld_d = 1'b0;
`ifdef MFE_LED7SEG_ARB_BLANK_EN
              state_d   = ST_LOAD;        // one dark frame, then IDLE
`else
              state_d   = ST_IDLE;
`endif
            end
          end else if (!(|others) || !dwell_sat) begin
            state_d = ST_LOAD;            // refresh the same owner
          end else begin
            // Owner still requesting is skipped because the pick starts after it.
            state_d   = ST_LOAD;
            owner_d   = pick_idx;
            dwell_clr = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    gap_d = gap_q;
    if (state_q == ST_SEND)                   gap_d = GAP_LOAD;
    else if (state_q == ST_HOLD && gap_q != '0) gap_d = gap_q - 1'b1;

    dwell_d = dwell_q;
    if (dwell_clr)                            dwell_d = '0;
    else if (state_q == ST_HOLD && !dwell_sat) dwell_d = dwell_q + 1'b1;

    out_dat_d = out_dat_q;
    if (state_q == ST_LOAD) out_dat_d = own_vld_q ? sel_dat : '1;
  end

  // Outputs, decoded from state.
  always_comb begin
    gnt     = (state_q != ST_IDLE && own_vld_q) ? owner_oh : '0;
    ack     = (state_q == ST_LOAD && own_vld_q) ? owner_oh : '0;
    out_vld = (state_q == ST_SEND);
  end

  assign out_dat = out_dat_q;

endmodule
